text_console: RTL

//  Parametrised text-mode character buffer between the CPU and the VGA text renderer.

---
 rtl/text_console_pkg.sv | 16 +
 rtl/text_console_if.sv | 13 +
 rtl/text_console_ram.sv | 37 +++
 rtl/text_console.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/text_console_pkg.sv
// Shared definitions for the streaming text console: control codes, printable range, FSM states.
package text_console_pkg;

  localparam logic [7:0] CC_NL    = 8'h0A;
  localparam logic [7:0] CC_BS    = 8'h08;
  localparam logic [7:0] CC_FF    = 8'h0C;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SCROLL
  } console_state_t;

endpackage

// File: rtl/text_console_if.sv
// CPU-side character stream handshake into the text console.
interface text_console_if #(
  parameter int unsigned CHAR_W = 8
);

  logic              in_valid;
  logic [CHAR_W-1:0] in_char;
  logic              in_ready;

  modport master (output in_valid, output in_char, input in_ready);
  modport slave  (input in_valid, input in_char, output in_ready);

endinterface

// File: rtl/text_console_ram.sv
// Simple dual-port character RAM: synchronous write on port A, registered read on port B.
module text_console_ram #(
  parameter int unsigned          DEPTH   = 2400,
  parameter int unsigned          ADDR_W  = 12,
  parameter int unsigned          DATA_W  = 8,
  parameter logic [DATA_W-1:0]    RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; addresses past the array end are dropped.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port; a same-cycle write to the read cell is not forwarded (old data returned).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= RST_VAL;
    end else if (32'(raddr) < DEPTH) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= RST_VAL;
    end
  end

endmodule

// File: rtl/text_console.sv
// Streaming text-mode character buffer: cursor handling, clear/scroll sweeps, video read port.
// Optional feature macro: TEXT_CONSOLE_CURSOR_EN adds the blinking vid_cursor output.
module text_console
  import text_console_pkg::*;
#(
  parameter int unsigned       COLS   = 80,
  parameter int unsigned       ROWS   = 30,
  parameter int unsigned       CHAR_W = 8,
  parameter logic [CHAR_W-1:0] BLANK  = 8'h20
) (
  input  logic                    clk,
  input  logic                    reset,
  text_console_if.slave           cpu,
  output logic                    busy,
  input  logic [$clog2(COLS)-1:0] vid_col,
  input  logic [$clog2(ROWS)-1:0] vid_row,
  output logic [CHAR_W-1:0]       vid_char,
  output logic [$clog2(COLS)-1:0] cur_col,
  output logic [$clog2(ROWS)-1:0] cur_row
`ifdef TEXT_CONSOLE_CURSOR_EN
  ,
  output logic                    vid_cursor
`endif
);

  localparam int unsigned COL_W  = $clog2(COLS);
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned CELLS  = COLS * ROWS;
  localparam int unsigned ADDR_W = $clog2(CELLS);

  console_state_t    state, state_n;
  logic [COL_W-1:0]  col_n;
  logic [ROW_W-1:0]  row_n;
  logic [ROW_W-1:0]  top, top_n;
  logic [ADDR_W-1:0] sweep_addr, sweep_addr_n;
  logic [ADDR_W-1:0] sweep_end, sweep_end_n;
  logic              xfer;
  logic              adv;
  logic              printable;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [CHAR_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr;
  logic [ROW_W-1:0]  cur_phys;

  // (a + b) mod ROWS for operands already below ROWS.
  function automatic logic [ROW_W-1:0] wrap_row(input logic [ROW_W-1:0] a,
                                                input logic [ROW_W-1:0] b);
    logic [ROW_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (ROW_W+1)'(ROWS)) begin
      s = s - (ROW_W+1)'(ROWS);
    end
    return s[ROW_W-1:0];
  endfunction

  // Linear RAM address of a physical (row, col) cell.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  assign xfer      = cpu.in_valid & cpu.in_ready;
  assign printable = (cpu.in_char >= CHAR_W'(PRINT_LO)) && (cpu.in_char <= CHAR_W'(PRINT_HI));
  assign cur_phys  = wrap_row(top, cur_row);
  assign raddr     = cell_addr(wrap_row(top, vid_row), vid_col);

  // State, cursor, scroll origin and sweep registers; handshake/status outputs registered from next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= CLEAR;
      cur_col      <= '0;
      cur_row      <= '0;
      top          <= '0;
      sweep_addr   <= '0;
      sweep_end    <= ADDR_W'(CELLS - 1);
      cpu.in_ready <= 1'b0;
      busy         <= 1'b1;
    end else begin
      state        <= state_n;
      cur_col      <= col_n;
      cur_row      <= row_n;
      top          <= top_n;
      sweep_addr   <= sweep_addr_n;
      sweep_end    <= sweep_end_n;
      cpu.in_ready <= (state_n == IDLE);
      busy         <= (state_n != IDLE);
    end
  end

  // Next-state logic: character decode in IDLE, one blank per cycle in CLEAR/SCROLL.
  always_comb begin
    state_n      = state;
    col_n        = cur_col;
    row_n        = cur_row;
    top_n        = top;
    sweep_addr_n = sweep_addr;
    sweep_end_n  = sweep_end;
    adv          = 1'b0;
    we           = 1'b0;
    waddr        = cell_addr(cur_phys, cur_col);
    wdata        = cpu.in_char;

    case (state)
      IDLE: begin
        if (xfer) begin
          if (printable) begin
            we = 1'b1;
            if (cur_col < COL_W'(COLS - 1)) begin
              col_n = cur_col + COL_W'(1);
            end else begin
              col_n = '0;
              adv   = 1'b1;
            end
          end else if (cpu.in_char == CHAR_W'(CC_NL)) begin
            col_n = '0;
            adv   = 1'b1;
          end else if (cpu.in_char == CHAR_W'(CC_BS)) begin
            if (cur_col != '0) begin
              col_n = cur_col - COL_W'(1);
              we    = 1'b1;
              waddr = cell_addr(cur_phys, cur_col - COL_W'(1));
              wdata = BLANK;
            end
          end else if (cpu.in_char == CHAR_W'(CC_FF)) begin
            col_n        = '0;
            row_n        = '0;
            top_n        = '0;
            sweep_addr_n = '0;
            sweep_end_n  = ADDR_W'(CELLS - 1);
            state_n      = CLEAR;
          end

          if (adv) begin
            if (cur_row < ROW_W'(ROWS - 1)) begin
              row_n = cur_row + ROW_W'(1);
            end else begin
              // The old top physical row becomes the new bottom row and is blanked.
              top_n        = wrap_row(top, ROW_W'(1));
              sweep_addr_n = cell_addr(top, '0);
              sweep_end_n  = cell_addr(top, '0) + ADDR_W'(COLS - 1);
              state_n      = SCROLL;
            end
          end
        end
      end

      CLEAR, SCROLL: begin
        we    = 1'b1;
        waddr = sweep_addr;
        wdata = BLANK;
        if (sweep_addr == sweep_end) begin
          state_n = IDLE;
        end else begin
          sweep_addr_n = sweep_addr + ADDR_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  text_console_ram #(
    .DEPTH  (CELLS),
    .ADDR_W (ADDR_W),
    .DATA_W (CHAR_W),
    .RST_VAL(BLANK)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(vid_char)
  );

`ifdef TEXT_CONSOLE_CURSOR_EN
  logic [23:0] blink_cnt;

  // Free-running blink counter; bit 23 low means the cursor phase is on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 24'(1);
    end
  end

  // Cursor flag registered alongside the RAM read so it lines up with vid_char.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_cursor <= 1'b0;
    end else begin
      vid_cursor <= ~blink_cnt[23] && (vid_row == cur_row) && (vid_col == cur_col);
    end
  end
`endif

endmodule
